safe_cpu_wrapper_csr: RTL



---
 rtl/safe_cpu_wrapper_csr.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/safe_cpu_wrapper_csr.sv
// Redundancy-mode CSR target for the safe CPU wrapper: register file on the reg bus
// plus the halt/switch/resume sequencer that applies a new single/DMR/TMR mode.
package reg_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

// state  | meaning
// IDLE   | no sequence running; CTRL writes accepted
// HALT   | halt requested on all harts, waiting for all halted or timeout
// SWITCH | single cycle, new mode applied, counter reloaded
// RESUME | halt released, waiting for all harts running or timeout
module safe_cpu_wrapper_csr #(
  parameter int unsigned NHARTS      = 3,
  parameter logic [15:0] TIMEOUT_RST = 16'h0400
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  reg_pkg::reg_req_t   reg_req_i,
  output reg_pkg::reg_rsp_t   reg_rsp_o,
  input  logic [NHARTS-1:0]   halted_i,
  output logic [NHARTS-1:0]   halt_req_o,
  output logic [1:0]          mode_o,
  output logic                busy_o,
  output logic                switch_done_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HALT,
    ST_SWITCH,
    ST_RESUME
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  mode_req_q, mode_req_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] timeout_q, timeout_d;
  logic [31:0] scratch_q, scratch_d;
  logic        to_err_q, to_err_d;
  logic        mode_err_q, mode_err_d;
  logic        done_q, done_d;

  logic [5:0]  offset;
  logic        sel_ctrl, sel_status, sel_timeout, sel_scratch;
  logic        wr;
  logic        ctrl_wr, start_req, start_ok, mode_err_set;
  logic [1:0]  wr_mode;
  logic        to_err_set, to_err_clr, mode_err_clr;
  logic        unused_addr_bits;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  assign offset      = reg_req_i.addr[7:2];
  assign sel_ctrl    = reg_req_i.valid && (offset == 6'd0);
  assign sel_status  = reg_req_i.valid && (offset == 6'd1);
  assign sel_timeout = reg_req_i.valid && (offset == 6'd2);
  assign sel_scratch = reg_req_i.valid && (offset == 6'd3);
  assign wr          = reg_req_i.write;

  assign unused_addr_bits = ^{reg_req_i.addr[31:8], reg_req_i.addr[1:0]};

  // CTRL is frozen while a sequence runs, so mode_req_q doubles as the latched target
  assign ctrl_wr      = sel_ctrl && wr && (state_q == ST_IDLE);
  assign wr_mode      = reg_req_i.wstrb[0] ? reg_req_i.wdata[1:0] : mode_req_q;
  assign start_req    = ctrl_wr && reg_req_i.wstrb[1] && reg_req_i.wdata[8];
  assign start_ok     = start_req && (wr_mode != 2'd3);
  assign mode_err_set = start_req && (wr_mode == 2'd3);
  assign to_err_clr   = sel_status && wr && reg_req_i.wstrb[0] && reg_req_i.wdata[3];
  assign mode_err_clr = sel_status && wr && reg_req_i.wstrb[0] && reg_req_i.wdata[4];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    to_err_set = 1'b0;
    halt_req_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          cnt_d   = timeout_q;
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        halt_req_o = '1;
        if (&halted_i) begin
          state_d = ST_SWITCH;
        end else if (cnt_q <= 16'd1) begin
          to_err_set = 1'b1;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_SWITCH: begin
        mode_d  = mode_req_q;
        cnt_d   = timeout_q;
        state_d = ST_RESUME;
      end
      ST_RESUME: begin
        if (halted_i == '0) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q <= 16'd1) begin
          to_err_set = 1'b1;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mode_req_d = mode_req_q;
    timeout_d  = timeout_q;
    scratch_d  = scratch_q;
    if (ctrl_wr && reg_req_i.wstrb[0] && !mode_err_set) begin
      mode_req_d = reg_req_i.wdata[1:0];
    end
    if (sel_timeout && wr) begin
      if (reg_req_i.wstrb[0]) timeout_d[7:0]  = reg_req_i.wdata[7:0];
      if (reg_req_i.wstrb[1]) timeout_d[15:8] = reg_req_i.wdata[15:8];
    end
    if (sel_scratch && wr) begin
      scratch_d = apply_strb(scratch_q, reg_req_i.wdata, reg_req_i.wstrb);
    end
    // a hardware set in the same cycle as a W1C must not be lost
    to_err_d   = (to_err_q & ~to_err_clr) | to_err_set;
    mode_err_d = (mode_err_q & ~mode_err_clr) | mode_err_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mode_q     <= 2'd0;
      mode_req_q <= 2'd0;
      timeout_q  <= TIMEOUT_RST;
      scratch_q  <= '0;
      to_err_q   <= 1'b0;
      mode_err_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      mode_req_q <= mode_req_d;
      timeout_q  <= timeout_d;
      scratch_q  <= scratch_d;
      to_err_q   <= to_err_d;
      mode_err_q <= mode_err_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = reg_req_i.valid;
    if (reg_req_i.valid) begin
      case (offset)
        6'd0: reg_rsp_o.rdata[1:0] = mode_req_q;
        6'd1: begin
          reg_rsp_o.rdata[1:0]          = mode_q;
          reg_rsp_o.rdata[2]            = (state_q != ST_IDLE);
          reg_rsp_o.rdata[3]            = to_err_q;
          reg_rsp_o.rdata[4]            = mode_err_q;
          reg_rsp_o.rdata[8 +: NHARTS]  = halted_i;
        end
        6'd2: reg_rsp_o.rdata[15:0] = timeout_q;
        6'd3: reg_rsp_o.rdata       = scratch_q;
        default: reg_rsp_o.error = 1'b1;
      endcase
    end
  end

  assign mode_o        = mode_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign switch_done_o = done_q;

endmodule
